// File: rtl/rv_core_pkg.sv
// Shared definitions for the RISC-V core front end: opcode constants,
// the canonical NOP encoding and the fetch FSM state type.
package rv_core_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_HALT = 2'd2
  } fetch_state_e;

  // True for every opcode the core implements (SYSTEM included).
  function automatic logic opc_is_legal(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction memory: synchronous write port for program loading,
// asynchronous read port for the fetch path. Contents are not reset.
module instr_mem #(
  parameter int IMEM_DEPTH = 256
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] waddr,
  input  logic [31:0]                   wdata,
  input  logic [$clog2(IMEM_DEPTH)-1:0] raddr,
  output logic [31:0]                   rdata
);

  logic [31:0] mem_q [IMEM_DEPTH];

  // Program-load write
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/instr_fetch_decode.sv
// Front end of the single-cycle core: owns the PC and instruction memory,
// fetches one word per cycle into IR, decodes its fields, handles stall,
// redirect with a one-slot squash, and a sticky halt on SYSTEM/illegal.
module instr_fetch_decode
  import rv_core_pkg::*;
#(
  parameter int                 WIDTH      = 32,
  parameter int                 IMEM_DEPTH = 256,
  parameter logic [WIDTH-1:0]   RESET_PC   = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic             redirect_en,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             imem_we,
  input  logic [WIDTH-1:0] imem_waddr,
  input  logic [31:0]      imem_wdata,
  output logic [WIDTH-1:0] fetch_pc,
  output logic [WIDTH-1:0] pc,
  output logic [31:0]      instr,
  output logic             valid,
  output logic [6:0]       opcode,
  output logic [2:0]       Funct3,
  output logic [6:0]       Funct7,
  output logic [4:0]       RS1,
  output logic [4:0]       RS2,
  output logic [4:0]       RD,
  output logic [11:0]      Imm_reg,
  output logic [4:0]       Shamt,
  output logic             read_en,
  output logic             write_en,
  output logic             halted,
  output logic             illegal
);

  localparam int AW = $clog2(IMEM_DEPTH);

  fetch_state_e     state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic             valid_q, valid_d;
  logic             halted_q, halted_d;
  logic             illegal_q, illegal_d;

  logic [31:0]      imem_rdata;
  logic             imem_we_eff;
  logic             halt_now;
  logic [WIDTH-1:0] redirect_tgt;

  // Address bits that never reach the word index.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{imem_waddr[WIDTH-1:AW+2], imem_waddr[1:0],
                              redirect_pc[1:0]};

  // Program loads only land while the core is not executing.
  assign imem_we_eff = imem_we && (state_q != FS_RUN);

  instr_mem #(
    .IMEM_DEPTH(IMEM_DEPTH)
  ) u_imem (
    .clk  (clk),
    .we   (imem_we_eff),
    .waddr(imem_waddr[AW+1:2]),
    .wdata(imem_wdata),
    .raddr(fetch_pc_q[AW+1:2]),
    .rdata(imem_rdata)
  );

  assign redirect_tgt = {redirect_pc[WIDTH-1:2], 2'b00};
  // IR is NOP whenever it is invalid, so valid_q gates only the real cases.
  assign halt_now = valid_q &&
                    ((ir_q[6:0] == OPC_SYSTEM) || !opc_is_legal(ir_q[6:0]));

  // Next-state logic for the fetch FSM, PC, IR and sticky status.
  // Stall freezes everything; a halt outranks a redirect.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    valid_d    = valid_q;
    illegal_d  = illegal_q;
    if (!stall) begin
      case (state_q)
        FS_IDLE: begin
          if (start) begin
            state_d = FS_RUN;
          end
        end
        FS_RUN: begin
          if (halt_now) begin
            state_d   = FS_HALT;
            valid_d   = 1'b0;
            ir_d      = NOP_INSTR;
            illegal_d = !opc_is_legal(ir_q[6:0]);
          end else begin
            pc_d       = fetch_pc_q;
            ir_d       = redirect_en ? NOP_INSTR : imem_rdata;
            valid_d    = !redirect_en;
            fetch_pc_d = redirect_en ? redirect_tgt : fetch_pc_q + WIDTH'(4);
          end
        end
        default: ;
      endcase
    end
    halted_d = (state_d == FS_HALT);
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FS_IDLE;
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      ir_q       <= NOP_INSTR;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      illegal_q  <= illegal_d;
    end
  end

  assign fetch_pc = fetch_pc_q;
  assign pc       = pc_q;
  assign instr    = ir_q;
  assign valid    = valid_q;
  assign halted   = halted_q;
  assign illegal  = illegal_q;

  assign opcode   = ir_q[6:0];
  assign Funct3   = ir_q[14:12];
  assign Funct7   = ir_q[31:25];
  assign RS1      = ir_q[19:15];
  assign RS2      = ir_q[24:20];
  assign RD       = ir_q[11:7];
  assign Imm_reg  = ir_q[31:20];
  assign Shamt    = ir_q[24:20];
  assign read_en  = valid_q && (ir_q[6:0] == OPC_LOAD);
  assign write_en = valid_q && (ir_q[6:0] == OPC_STORE);

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: directed scenarios plus randomized runs,
// all checked against a behavioural model of the fetch front end.
module tb_instr_fetch_decode;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;
  logic        start, stall, redirect_en, imem_we;
  logic [31:0] redirect_pc, imem_waddr, imem_wdata;
  logic [31:0] fetch_pc, pc, instr;
  logic        valid, read_en, write_en, halted, illegal;
  logic [6:0]  opcode, Funct7;
  logic [2:0]  Funct3;
  logic [4:0]  RS1, RS2, RD, Shamt;
  logic [11:0] Imm_reg;

  int n_chk  = 0;
  int n_pass = 0;

  instr_fetch_decode #(
    .WIDTH(32), .IMEM_DEPTH(DEPTH), .RESET_PC(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .fetch_pc(fetch_pc), .pc(pc), .instr(instr), .valid(valid),
    .opcode(opcode), .Funct3(Funct3), .Funct7(Funct7),
    .RS1(RS1), .RS2(RS2), .RD(RD), .Imm_reg(Imm_reg), .Shamt(Shamt),
    .read_en(read_en), .write_en(write_en), .halted(halted), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_mem [DEPTH];
  int          m_mode;          // 0 idle, 1 running, 2 halted
  logic [31:0] m_fpc, m_pc, m_ir;
  logic        m_valid, m_ill;

  function automatic bit is_legal(input logic [6:0] op);
    return op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                      7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                      7'b0110011, 7'b1110011};
  endfunction

  function automatic int word_idx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic model_reset();
    m_mode = 0; m_fpc = 0; m_pc = 0; m_ir = 32'h13; m_valid = 0; m_ill = 0;
  endtask

  task automatic model_step();
    if (imem_we && m_mode != 1) m_mem[word_idx(imem_waddr)] = imem_wdata;
    if (stall) return;
    if (m_mode == 0) begin
      if (start) m_mode = 1;
    end else if (m_mode == 1) begin
      if (m_valid && (m_ir[6:0] == 7'b1110011 || !is_legal(m_ir[6:0]))) begin
        m_mode = 2; m_ill = !is_legal(m_ir[6:0]); m_valid = 0; m_ir = 32'h13;
      end else begin
        m_pc    = m_fpc;
        m_ir    = redirect_en ? 32'h13 : m_mem[word_idx(m_fpc)];
        m_valid = !redirect_en;
        m_fpc   = redirect_en ? (redirect_pc & ~32'h3) : m_fpc + 4;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic compare_all();
    chk("fetch_pc", fetch_pc, m_fpc);
    chk("pc", pc, m_pc);
    chk("instr", instr, m_ir);
    chk("valid", 32'(valid), 32'(m_valid));
    chk("halted", 32'(halted), 32'(m_mode == 2));
    chk("illegal", 32'(illegal), 32'(m_ill));
    chk("opcode", 32'(opcode), 32'(m_ir[6:0]));
    chk("Funct3", 32'(Funct3), 32'(m_ir[14:12]));
    chk("Funct7", 32'(Funct7), 32'(m_ir[31:25]));
    chk("RS1", 32'(RS1), 32'(m_ir[19:15]));
    chk("RS2", 32'(RS2), 32'(m_ir[24:20]));
    chk("RD", 32'(RD), 32'(m_ir[11:7]));
    chk("Imm_reg", 32'(Imm_reg), 32'(m_ir[31:20]));
    chk("Shamt", 32'(Shamt), 32'(m_ir[24:20]));
    chk("read_en", 32'(read_en), 32'(m_valid && m_ir[6:0] == 7'b0000011));
    chk("write_en", 32'(write_en), 32'(m_valid && m_ir[6:0] == 7'b0100011));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    start = 0; stall = 0; redirect_en = 0; redirect_pc = 0;
    imem_we = 0; imem_waddr = 0; imem_wdata = 0;
  endtask

  // Assert reset between edges and check that outputs drop immediately.
  task automatic async_reset(input string tag);
    idle_inputs();
    #3 rst = 1'b0;
    #1;
    chk({tag, "_fetch_pc"}, fetch_pc, 32'h0);
    chk({tag, "_pc"}, pc, 32'h0);
    chk({tag, "_instr"}, instr, 32'h13);
    chk({tag, "_valid"}, 32'(valid), 32'h0);
    chk({tag, "_halted"}, 32'(halted), 32'h0);
    chk({tag, "_illegal"}, 32'(illegal), 32'h0);
    chk({tag, "_rw"}, 32'({read_en, write_en}), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    imem_we = 1; imem_waddr = addr; imem_wdata = data;
    cycle();
    imem_we = 0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  legal_ops [9];
    logic [31:0] r;
    int          sel;
    legal_ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                  7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011};
    r   = $urandom;
    sel = $urandom_range(0, 15);
    if (sel == 0) return r;
    if (sel == 1) return {r[31:7], 7'b1110011};
    return {r[31:7], legal_ops[$urandom_range(0, 8)]};
  endfunction

  initial begin
    idle_inputs();
    rst = 1'b0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    rst = 1'b1;

    // Program: three addi, ecall at 0xC, load at 0x20, store at 0x24.
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] w;
      w = 32'h13;
      if (i == 0) w = 32'h0050_0093;
      if (i == 1) w = 32'h0070_8113;
      if (i == 2) w = 32'hFFF1_0193;
      if (i == 3) w = 32'h0000_0073;
      if (i == 8) w = 32'h0000_2083;
      if (i == 9) w = 32'h0011_2023;
      load(32'(i * 4), w);
    end

    start = 1; cycle(); start = 0;
    chk("idle_latency_valid", 32'(valid), 32'h0);
    cycle();
    chk("first_pc", pc, 32'h0);
    chk("first_valid", 32'(valid), 32'h1);
    chk("first_RD", 32'(RD), 32'd1);
    chk("first_RS1", 32'(RS1), 32'd0);
    chk("first_Imm", 32'(Imm_reg), 32'd5);
    cycle();
    chk("second_pc", pc, 32'h4);

    redirect_en = 1; redirect_pc = 32'h22;
    cycle();
    redirect_en = 0;
    chk("bubble_valid", 32'(valid), 32'h0);
    chk("bubble_instr", instr, 32'h13);
    cycle();
    chk("target_pc", pc, 32'h20);
    chk("load_read_en", 32'(read_en), 32'h1);
    cycle();
    chk("store_write_en", 32'(write_en), 32'h1);

    stall = 1;
    repeat (3) cycle();
    chk("stall_pc", pc, 32'h24);
    chk("stall_fetch_pc", fetch_pc, 32'h28);
    stall = 0;

    repeat (7) cycle();
    chk("wrap_pc", pc, 32'h40);
    chk("wrap_instr", instr, 32'h0050_0093);
    repeat (3) cycle();
    chk("ecall_in_ir", instr, 32'h0000_0073);
    cycle();
    chk("ecall_halted", 32'(halted), 32'h1);
    chk("ecall_illegal", 32'(illegal), 32'h0);
    chk("ecall_valid", 32'(valid), 32'h0);
    cycle();
    chk("halt_fetch_frozen", fetch_pc, 32'h50);

    // Write in HALT must land: illegal opcode at 0x0.
    load(32'h0, 32'h0000_007F);
    async_reset("rst_after_halt");
    start = 1; cycle(); start = 0;
    cycle();
    cycle();
    chk("illegal_halted", 32'(halted), 32'h1);
    chk("illegal_flag", 32'(illegal), 32'h1);

    // Randomized rounds, some ending in a mid-run asynchronous reset.
    for (int r = 0; r < 8; r++) begin
      async_reset("rst_round");
      for (int i = 0; i < DEPTH; i++) load(32'(i * 4) + 32'(DEPTH * 4 * $urandom_range(0, 3)), rand_instr());
      start = 1; cycle(); start = 0;
      for (int c = 0; c < 60; c++) begin
        start       = ($urandom_range(0, 7) == 0);
        stall       = ($urandom_range(0, 3) == 0);
        redirect_en = ($urandom_range(0, 5) == 0);
        redirect_pc = $urandom;
        imem_we     = ($urandom_range(0, 3) == 0);
        imem_waddr  = $urandom;
        imem_wdata  = rand_instr();
        cycle();
      end
      idle_inputs();
      if (r % 2 == 1) begin
        start = 1; cycle();
        async_reset("rst_midrun");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
